// File: rtl/alu_op_sequencer.sv
// Controller side of the tri-state ALU: issues one operation, waits for the inputs to settle, enables the result bus and returns the sample.
// Optional macro ALU_OP_SEQUENCER_STATS_EN adds saturating OpCount/ErrCount handshake counters.
module alu_op_sequencer #(
    parameter int BitWidth     = 8,
    parameter int SettleCycles = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [3:0]          ReqOp,
    input  logic [BitWidth-1:0] ReqA,
    input  logic [BitWidth-1:0] ReqB,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [BitWidth-1:0] RspLow,
    output logic [BitWidth-1:0] RspHigh,
    output logic [3:0]          RspFlags,
    output logic                RspErr,
    output logic [BitWidth-1:0] AluA,
    output logic [BitWidth-1:0] AluB,
    output logic [3:0]          AluFunc,
    output logic                AluOE,
    input  logic [BitWidth-1:0] AluResLow,
    input  logic [BitWidth-1:0] AluResHigh,
    input  logic [3:0]          AluFlags
`ifdef ALU_OP_SEQUENCER_STATS_EN
    ,
    output logic [15:0]         OpCount,
    output logic [7:0]          ErrCount
`endif
);

    localparam int SETTLE_LOAD = (SettleCycles < 1) ? 1 : SettleCycles;
    localparam int CW          = $clog2(SETTLE_LOAD + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        READ0,
        READ1,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   settle_cnt;
    logic            op_legal;
    logic            accept;
    logic            rsp_done;

    assign op_legal = ~ReqOp[3];
    assign accept   = (state == IDLE) && ReqValid;
    assign rsp_done = (state == RESP) && RspReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ReqReady   = 1'b0;
        RspValid   = 1'b0;
        AluOE      = 1'b1;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    state_next = op_legal ? SETTLE : RESP;
                end
            end
            SETTLE: begin
                if (settle_cnt == CW'(1)) begin
                    state_next = READ0;
                end
            end
            READ0: begin
                AluOE      = 1'b0;
                state_next = READ1;
            end
            READ1: begin
                AluOE      = 1'b0;
                state_next = RESP;
            end
            RESP: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALU inputs only change on a legal accept so they stay quiet through RESP.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            AluA       <= '0;
            AluB       <= '0;
            AluFunc    <= '0;
            settle_cnt <= '0;
        end else if (accept && op_legal) begin
            AluA       <= ReqA;
            AluB       <= ReqB;
            AluFunc    <= ReqOp;
            settle_cnt <= CW'(SETTLE_LOAD);
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt - CW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RspLow   <= '0;
            RspHigh  <= '0;
            RspFlags <= '0;
            RspErr   <= 1'b0;
        end else if (accept && !op_legal) begin
            RspLow   <= '0;
            RspHigh  <= '0;
            RspFlags <= '0;
            RspErr   <= 1'b1;
        end else if (state == READ1) begin
            RspLow   <= AluResLow;
            RspHigh  <= AluResHigh;
            RspFlags <= AluFlags;
            RspErr   <= 1'b0;
        end
    end

`ifdef ALU_OP_SEQUENCER_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            OpCount  <= '0;
            ErrCount <= '0;
        end else if (rsp_done) begin
            if (RspErr) begin
                if (ErrCount != '1) ErrCount <= ErrCount + 8'd1;
            end else begin
                if (OpCount != '1) OpCount <= OpCount + 16'd1;
            end
        end
    end
`else
    logic unused_rsp_done;
    assign unused_rsp_done = rsp_done;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural tri-state ALU on the result bus.
// Define ALU_OP_SEQUENCER_STATS_EN to also check the handshake counters.
module tb_alu_op_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       ReqValid = 1'b0;
    logic       ReqReady;
    logic [3:0] ReqOp = '0;
    logic [7:0] ReqA = '0;
    logic [7:0] ReqB = '0;
    logic       RspValid;
    logic       RspReady = 1'b0;
    logic [7:0] RspLow;
    logic [7:0] RspHigh;
    logic [3:0] RspFlags;
    logic       RspErr;
    logic [7:0] AluA;
    logic [7:0] AluB;
    logic [3:0] AluFunc;
    logic       AluOE;
    wire  [7:0] AluResLow;
    wire  [7:0] AluResHigh;
    logic [3:0] AluFlags;
`ifdef ALU_OP_SEQUENCER_STATS_EN
    logic [15:0] OpCount;
    logic [7:0]  ErrCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    alu_op_sequencer #(.BitWidth(8), .SettleCycles(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
        .RspValid(RspValid), .RspReady(RspReady), .RspLow(RspLow), .RspHigh(RspHigh),
        .RspFlags(RspFlags), .RspErr(RspErr),
        .AluA(AluA), .AluB(AluB), .AluFunc(AluFunc), .AluOE(AluOE),
        .AluResLow(AluResLow), .AluResHigh(AluResHigh), .AluFlags(AluFlags)
`ifdef ALU_OP_SEQUENCER_STATS_EN
        , .OpCount(OpCount), .ErrCount(ErrCount)
`endif
    );

    // Behavioural ALU: {ResHigh,ResLow} driven only while OE is low.
    logic [7:0] m_low;
    logic [7:0] m_high;
    logic [8:0] m_sum;
    always_comb begin
        m_low    = '0;
        m_high   = '0;
        m_sum    = '0;
        AluFlags = '0;
        case (AluFunc)
            4'd0: begin
                m_sum       = {1'b0, AluA} + {1'b0, AluB};
                m_low       = m_sum[7:0];
                m_high      = {7'b0, m_sum[8]};
                AluFlags[1] = m_sum[8];
                AluFlags[3] = (AluA[7] == AluB[7]) && (m_low[7] != AluA[7]);
            end
            4'd1: begin
                m_sum       = {1'b0, AluA} - {1'b0, AluB};
                m_low       = m_sum[7:0];
                AluFlags[1] = m_sum[8];
                AluFlags[3] = (AluA[7] != AluB[7]) && (m_low[7] != AluA[7]);
            end
            4'd2: m_low = AluA & AluB;
            4'd3: m_low = AluA | AluB;
            4'd4: m_low = AluA ^ AluB;
            default: m_low = '0;
        endcase
        AluFlags[0] = (m_low == 8'h00);
        AluFlags[2] = m_low[7];
    end
    assign AluResLow  = AluOE ? 8'bz : m_low;
    assign AluResHigh = AluOE ? 8'bz : m_high;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one request; returns edges from the accept edge (counted as 1) to RspValid and OE-low cycles.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int oe_low);
        lat    = 0;
        oe_low = 0;
        @(negedge Clk);
        ReqValid = 1'b1;
        ReqOp    = op;
        ReqA     = a;
        ReqB     = b;
        chk("req_ready_idle", ReqReady, 1);
        @(posedge Clk);
        lat = 1;
        @(negedge Clk);
        ReqValid = 1'b0;
        while (!RspValid && lat < 20) begin
            if (!AluOE) oe_low++;
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
    endtask

    task automatic finish_rsp();
        RspReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("idle_req_ready", ReqReady, 1);
        chk("idle_rsp_valid", RspValid, 0);
        RspReady = 1'b0;
    endtask

    int lat;
    int oe_low;

    initial begin
        // Asynchronous reset before any clock edge
        #3 Reset = 1'b1;
        #1;
        chk("rst_req_ready", ReqReady, 1);
        chk("rst_rsp_valid", RspValid, 0);
        chk("rst_rsp_err", RspErr, 0);
        chk("rst_alu_oe", AluOE, 1);
        chk("rst_alu_abf", {AluA, AluB, AluFunc}, 0);
        chk("rst_rsp_data", {RspLow, RspHigh, RspFlags}, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Add 7F+01
        RspReady = 1'b1;
        issue(4'd0, 8'h7F, 8'h01, lat, oe_low);
        chk("add_latency", lat, 5);
        chk("add_oe_low_cycles", oe_low, 2);
        chk("add_low", RspLow, 8'h80);
        chk("add_high", RspHigh, 8'h00);
        chk("add_flags", RspFlags, 4'b1100);
        chk("add_err", RspErr, 0);
        chk("add_oe_resp", AluOE, 1);
        finish_rsp();

        // Sub 05-05 with a 4-cycle stall
        issue(4'd1, 8'h05, 8'h05, lat, oe_low);
        chk("sub_latency", lat, 5);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", RspValid, 1);
            chk("stall_low", RspLow, 8'h00);
            chk("stall_flags", RspFlags, 4'b0001);
            chk("stall_req_ready", ReqReady, 0);
            chk("stall_oe", AluOE, 1);
            @(negedge Clk);
        end
        finish_rsp();

        // Illegal op leaves the ALU inputs from the Sub
        issue(4'b1010, 8'h33, 8'h44, lat, oe_low);
        chk("ill_latency", lat, 1);
        chk("ill_err", RspErr, 1);
        chk("ill_data", {RspLow, RspHigh, RspFlags}, 0);
        chk("ill_oe_low_cycles", oe_low, 0);
        chk("ill_oe", AluOE, 1);
        chk("ill_func", AluFunc, 4'd1);
        chk("ill_a", AluA, 8'h05);
        finish_rsp();

        // Reset while in READ1
        @(negedge Clk);
        ReqValid = 1'b1;
        ReqOp    = 4'd3;
        ReqA     = 8'h11;
        ReqB     = 8'h22;
        @(posedge Clk);
        @(negedge Clk);
        ReqValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 chk("pre_abort_oe", AluOE, 0);
        #1 Reset = 1'b1;
        #1;
        chk("abort_oe", AluOE, 1);
        chk("abort_rsp_valid", RspValid, 0);
        chk("abort_req_ready", ReqReady, 1);
        @(negedge Clk);
        Reset = 1'b0;
        oe_low = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (RspValid) oe_low++;
        end
        chk("abort_no_rsp", oe_low, 0);

        issue(4'd2, 8'hF0, 8'h3C, lat, oe_low);
        chk("and_latency", lat, 5);
        chk("and_low", RspLow, 8'h30);
        chk("and_flags", RspFlags, 4'b0000);
        chk("and_err", RspErr, 0);
        finish_rsp();

        // Back-to-back with ReqValid held high
        @(negedge Clk);
        RspReady = 1'b1;
        ReqValid = 1'b1;
        ReqOp    = 4'd0;
        ReqA     = 8'h01;
        ReqB     = 8'h02;
        @(posedge Clk);
        @(negedge Clk);
        ReqOp = 4'd4;
        ReqA  = 8'hAA;
        ReqB  = 8'h0F;
        lat   = 1;
        while (!RspValid && lat < 20) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        chk("b2b1_latency", lat, 5);
        chk("b2b1_low", RspLow, 8'h03);
        chk("b2b1_flags", RspFlags, 4'b0000);
        @(posedge Clk);
        @(negedge Clk);
        chk("b2b_idle_after_hs", ReqReady, 1);
        @(posedge Clk);
        @(negedge Clk);
        ReqValid = 1'b0;
        chk("b2b2_accepted", ReqReady, 0);
        chk("b2b2_a", AluA, 8'hAA);
        chk("b2b2_func", AluFunc, 4'd4);
        lat = 1;
        while (!RspValid && lat < 20) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        chk("b2b2_latency", lat, 5);
        chk("b2b2_low", RspLow, 8'hA5);
        chk("b2b2_flags", RspFlags, 4'b0100);
        finish_rsp();
`ifdef ALU_OP_SEQUENCER_STATS_EN
        // Counters were cleared by the abort reset: And plus two back-to-back ops since.
        chk("stats_op_count", OpCount, 16'd3);
        chk("stats_err_count", ErrCount, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
